// File: rtl/dram_paged.sv
// ---------------------------------------------------------------------------
// dram_paged -- clocked multiplexed-address DRAM array model.
//
// Decodes nRAS/nCAS/nWRITE (all sampled on the rising CLK edge) into row
// open, page-mode column accesses, early and late (read-modify-write)
// writes, RAS-only refresh and CAS-before-RAS refresh, with an optional
// per-row retention check.
//
// Ports
//   CLK          in   model clock, strobes sampled on rising edge
//   nRESET       in   synchronous active-low reset (memory contents kept)
//   A            in   multiplexed row/column address
//   nRAS         in   row strobe, active low
//   nCAS         in   column strobe, active low
//   nWRITE       in   write enable, active low
//   Din          in   write data
//   Dout         out  read data, holds last value when not driven
//   Dout_oe      out  1 while Dout drives the shared bus
//   refresh_err  out  1-cycle pulse: an expired (decayed) row was opened
//   protocol_err out  1-cycle pulse: illegal strobe sequence
//   dbg_state    out  FSM state (0 IDLE, 1 ROW_OPEN, 2 COL_ACTIVE, 3 CBR)
//   dbg_cbr_cnt  out  next row to be refreshed by a CAS-before-RAS cycle
//
// Output handshake: Dout is valid exactly while Dout_oe is 1. Dout_oe rises
// on the edge that samples the CAS fall of a read and falls on the first
// edge that samples nCAS high. There is no back-pressure.
// ---------------------------------------------------------------------------
module dram_paged #(
    parameter int                   ADDR_BITS  = 7,
    parameter int                   DATA_BITS  = 1,
    parameter int                   RETENTION  = 0,
    parameter logic [DATA_BITS-1:0] INIT_VALUE = '0
) (
    input  logic                 CLK,
    input  logic                 nRESET,
    input  logic [ADDR_BITS-1:0] A,
    input  logic                 nRAS,
    input  logic                 nCAS,
    input  logic                 nWRITE,
    input  logic [DATA_BITS-1:0] Din,
    output logic [DATA_BITS-1:0] Dout,
    output logic                 Dout_oe,
    output logic                 refresh_err,
    output logic                 protocol_err,
    output logic [1:0]           dbg_state,
    output logic [ADDR_BITS-1:0] dbg_cbr_cnt
);

    localparam int ROWS  = 1 << ADDR_BITS;
    localparam int WORDS = 1 << (2 * ADDR_BITS);
    localparam int AGE_W = (RETENTION > 0) ? $clog2(RETENTION + 1) : 1;
    localparam logic [AGE_W-1:0] AGE_MAX    = AGE_W'(RETENTION);
    localparam logic [AGE_W-1:0] AGE_EXPIRE = AGE_W'((RETENTION > 0) ? RETENTION - 1 : 0);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ROW_OPEN   = 2'd1,
        COL_ACTIVE = 2'd2,
        CBR        = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   row_q, row_d;
    logic [ADDR_BITS-1:0]   col_q, col_d;
    logic [ADDR_BITS-1:0]   cbr_q, cbr_d;
    logic [DATA_BITS-1:0]   dout_q, dout_d;
    logic                   oe_q, oe_d;
    logic                   rerr_q, rerr_d;
    logic                   perr_q, perr_d;
    logic                   prev_ras_q, prev_cas_q, prev_we_q;
    logic [AGE_W-1:0]       age_q [ROWS];

    // Words are stored XOR INIT_VALUE, so an array that powers up all-zero
    // reads back as INIT_VALUE without needing a fill pass.
    logic [DATA_BITS-1:0]   mem_q [WORDS];

    logic                   ras_fall, ras_rise, cas_fall, cas_rise, we_fall;
    logic                   wr_en;
    logic [2*ADDR_BITS-1:0] wr_addr;
    logic                   open_en;
    logic [ADDR_BITS-1:0]   open_row;
    logic                   expired;
    logic [DATA_BITS-1:0]   rd_word;

    assign ras_fall = prev_ras_q & ~nRAS;
    assign ras_rise = ~prev_ras_q & nRAS;
    assign cas_fall = prev_cas_q & ~nCAS;
    assign cas_rise = ~prev_cas_q & nCAS;
    assign we_fall  = prev_we_q & ~nWRITE;

    assign rd_word  = mem_q[{row_q, A}] ^ INIT_VALUE;

    // A row counts as expired on the cycle its age would reach RETENTION.
    assign expired  = (RETENTION > 0) && (age_q[open_row] >= AGE_EXPIRE);

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        cbr_d    = cbr_q;
        dout_d   = dout_q;
        oe_d     = nCAS ? 1'b0 : oe_q;
        perr_d   = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = {row_q, col_q};
        open_en  = 1'b0;
        open_row = A;

        if (ras_rise) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ras_fall) begin
                        open_en = 1'b1;
                        if (cas_fall) begin
                            // Simultaneous strobes: open the row, drop the CAS.
                            row_d   = A;
                            perr_d  = 1'b1;
                            state_d = ROW_OPEN;
                        end else if (!prev_cas_q) begin
                            open_row = cbr_q;
                            cbr_d    = cbr_q + ADDR_BITS'(1);
                            state_d  = CBR;
                        end else begin
                            row_d   = A;
                            state_d = ROW_OPEN;
                        end
                    end else if (cas_fall && !nRAS) begin
                        // CAS with RAS low but no row open. A CAS fall with
                        // RAS high is the legal CBR set-up.
                        perr_d = 1'b1;
                    end
                end
                ROW_OPEN: begin
                    if (cas_fall) begin
                        col_d   = A;
                        state_d = COL_ACTIVE;
                        if (!nWRITE) begin
                            wr_en   = 1'b1;
                            wr_addr = {row_q, A};
                        end else begin
                            dout_d = rd_word;
                            oe_d   = 1'b1;
                        end
                    end
                end
                COL_ACTIVE: begin
                    if (cas_rise) begin
                        state_d = ROW_OPEN;
                    end else if (we_fall) begin
                        wr_en = 1'b1;
                    end
                end
                CBR: begin
                    if (cas_fall) begin
                        perr_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        rerr_d = open_en & expired;
    end

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            state_q    <= IDLE;
            row_q      <= '0;
            col_q      <= '0;
            cbr_q      <= '0;
            dout_q     <= '0;
            oe_q       <= 1'b0;
            rerr_q     <= 1'b0;
            perr_q     <= 1'b0;
            prev_ras_q <= 1'b1;
            prev_cas_q <= 1'b1;
            prev_we_q  <= 1'b1;
            for (int r = 0; r < ROWS; r++) begin
                age_q[r] <= '0;
            end
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            cbr_q      <= cbr_d;
            dout_q     <= dout_d;
            oe_q       <= oe_d;
            rerr_q     <= rerr_d;
            perr_q     <= perr_d;
            prev_ras_q <= nRAS;
            prev_cas_q <= nCAS;
            prev_we_q  <= nWRITE;
            for (int r = 0; r < ROWS; r++) begin
                if (open_en && open_row == ADDR_BITS'(r)) begin
                    age_q[r] <= '0;
                end else if (age_q[r] != AGE_MAX) begin
                    age_q[r] <= age_q[r] + AGE_W'(1);
                end
            end
        end
    end

    // Array has no reset; a reset cycle only suppresses writes and decay.
    always_ff @(posedge CLK) begin
        if (nRESET) begin
            if (open_en && expired) begin
                for (int c = 0; c < ROWS; c++) begin
                    mem_q[{open_row, ADDR_BITS'(c)}] <= INIT_VALUE;
                end
            end
            if (wr_en) begin
                mem_q[wr_addr] <= Din ^ INIT_VALUE;
            end
        end
    end

    assign Dout         = dout_q;
    assign Dout_oe      = oe_q;
    assign refresh_err  = rerr_q;
    assign protocol_err = perr_q;
    assign dbg_state    = state_q;
    assign dbg_cbr_cnt  = cbr_q;

endmodule

// File: tb/tb_dram_paged.sv
// ---------------------------------------------------------------------------
// tb_dram_paged -- directed bench for dram_paged (4-bit words, 16x16 array,
// RETENTION = 100). Reads are pushed into exp_q by the driver tasks; the
// monitor pops one entry on every rising edge of Dout_oe and also counts
// refresh_err / protocol_err pulses for comparison at the end of each test.
// ---------------------------------------------------------------------------
module tb_dram_paged;

    localparam int AB  = 4;
    localparam int DB  = 4;
    localparam int RET = 100;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          nreset;
    logic [AB-1:0] addr;
    logic          nras, ncas, nwrite;
    logic [DB-1:0] din;
    logic [DB-1:0] dout;
    logic          dout_oe, refresh_err, protocol_err;
    logic [1:0]    dbg_state;
    logic [AB-1:0] dbg_cbr_cnt;

    always #5 clk = ~clk;

    dram_paged #(
        .ADDR_BITS (AB),
        .DATA_BITS (DB),
        .RETENTION (RET),
        .INIT_VALUE('0)
    ) dut (
        .CLK         (clk),
        .nRESET      (nreset),
        .A           (addr),
        .nRAS        (nras),
        .nCAS        (ncas),
        .nWRITE      (nwrite),
        .Din         (din),
        .Dout        (dout),
        .Dout_oe     (dout_oe),
        .refresh_err (refresh_err),
        .protocol_err(protocol_err),
        .dbg_state   (dbg_state),
        .dbg_cbr_cnt (dbg_cbr_cnt)
    );

    // ---------------- scoreboard state ----------------
    int            checks    = 0;
    int            errors    = 0;
    int            perr_seen = 0;
    int            rerr_seen = 0;
    int            exp_perr  = 0;
    int            exp_rerr  = 0;
    logic          prev_oe   = 1'b0;
    logic [DB-1:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: samples on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (dout_oe && !prev_oe) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL read_unexpected: got Dout=%0h with no read pending (t=%0t)", dout, $time);
            end else begin
                check("read_data", dout, exp_q.pop_front());
            end
        end
        if (protocol_err) perr_seen++;
        if (refresh_err)  rerr_seen++;
        prev_oe = dout_oe;
    end

    // ---------------- driver tasks ----------------
    task automatic set_pins(input logic ras, input logic cas, input logic we,
                            input logic [AB-1:0] a, input logic [DB-1:0] d);
        nras   = ras;
        ncas   = cas;
        nwrite = we;
        addr   = a;
        din    = d;
    endtask

    // One call = one sampled rising edge with these pin values.
    task automatic drive(input logic ras, input logic cas, input logic we,
                         input logic [AB-1:0] a, input logic [DB-1:0] d);
        @(negedge clk);
        set_pins(ras, cas, we, a, d);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b1, 1'b1, 1'b1, '0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        nreset = 1'b0;
        set_pins(1'b1, 1'b1, 1'b1, '0, '0);
        @(negedge clk);
        @(negedge clk);
        nreset = 1'b1;
    endtask

    // Early write: four edges (RAS fall, CAS fall, CAS rise, RAS rise).
    task automatic write_word(input logic [AB-1:0] r, input logic [AB-1:0] c,
                              input logic [DB-1:0] d);
        drive(1'b0, 1'b1, 1'b1, r, '0);
        drive(1'b0, 1'b0, 1'b0, c, d);
        drive(1'b0, 1'b1, 1'b1, c, d);
        drive(1'b1, 1'b1, 1'b1, '0, '0);
    endtask

    task automatic read_word(input logic [AB-1:0] r, input logic [AB-1:0] c,
                             input logic [DB-1:0] exp);
        drive(1'b0, 1'b1, 1'b1, r, '0);
        exp_q.push_back(exp);
        drive(1'b0, 1'b0, 1'b1, c, '0);
        @(negedge clk);
        check("read_oe_latency", dout_oe, 1);
        set_pins(1'b0, 1'b1, 1'b1, c, '0);
        drive(1'b1, 1'b1, 1'b1, '0, '0);
    endtask

    // ---------------- stimulus ----------------
    logic [DB-1:0] page_pat [4] = '{4'h1, 4'h0, 4'h1, 4'h1};

    initial begin
        nreset = 1'b0;
        set_pins(1'b1, 1'b1, 1'b1, '0, '0);
        repeat (2) @(negedge clk);

        // Reset state
        check("reset_dout", dout, 0);
        check("reset_oe", dout_oe, 0);
        check("reset_state", dbg_state, 0);
        check("reset_cbr_cnt", dbg_cbr_cnt, 0);
        check("reset_perr", protocol_err, 0);
        check("reset_rerr", refresh_err, 0);
        nreset = 1'b1;

        // 1: early write / read of {5,9}
        write_word(4'd5, 4'd9, 4'hF);
        read_word(4'd5, 4'd9, 4'hF);
        write_word(4'd5, 4'd9, 4'h0);
        read_word(4'd5, 4'd9, 4'h0);

        // 2: page mode on row 3, one RAS for all writes, one for all reads
        drive(1'b0, 1'b1, 1'b1, 4'd3, '0);
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 1'b0, 1'b0, AB'(c), page_pat[c]);
            drive(1'b0, 1'b1, 1'b1, AB'(c), page_pat[c]);
        end
        drive(1'b1, 1'b1, 1'b1, '0, '0);
        drive(1'b0, 1'b1, 1'b1, 4'd3, '0);
        for (int c = 0; c < 4; c++) begin
            exp_q.push_back(page_pat[c]);
            drive(1'b0, 1'b0, 1'b1, AB'(c), '0);
            drive(1'b0, 1'b1, 1'b1, AB'(c), '0);
        end
        drive(1'b1, 1'b1, 1'b1, '0, '0);

        // 3: read-modify-write of {2,2}
        write_word(4'd2, 4'd2, 4'hA);
        drive(1'b0, 1'b1, 1'b1, 4'd2, '0);
        exp_q.push_back(4'hA);
        drive(1'b0, 1'b0, 1'b1, 4'd2, '0);
        drive(1'b0, 1'b0, 1'b0, 4'd2, 4'h5);
        @(negedge clk);
        check("rmw_dout_held", dout, 4'hA);
        check("rmw_oe_held", dout_oe, 1);
        set_pins(1'b0, 1'b1, 1'b1, 4'd2, '0);
        drive(1'b1, 1'b1, 1'b1, '0, '0);
        read_word(4'd2, 4'd2, 4'h5);

        // 4: three CAS-before-RAS refreshes
        do_reset();
        drive(1'b1, 1'b0, 1'b1, '0, '0);
        repeat (3) begin
            drive(1'b0, 1'b0, 1'b1, '0, '0);
            drive(1'b1, 1'b0, 1'b1, '0, '0);
        end
        drive(1'b1, 1'b1, 1'b1, '0, '0);
        @(negedge clk);
        check("cbr_count", dbg_cbr_cnt, 3);
        check("cbr_state_idle", dbg_state, 0);
        read_word(4'd3, 4'd0, 4'h1);
        read_word(4'd2, 4'd2, 4'h5);
        idle(2);
        check("perr_count_t1_4", perr_seen, exp_perr);
        check("rerr_count_t1_4", rerr_seen, exp_rerr);

        // 5: retention. Row 7 is refreshed at the write's RAS-fall edge E;
        // write_word uses edges E..E+3, idle(k) adds k more, so the reopen
        // edge is E+4+k. Reopen 100 cycles later -> expired, 99 -> fine.
        do_reset();
        write_word(4'd7, 4'd1, 4'h9);
        idle(96);
        drive(1'b0, 1'b1, 1'b1, 4'd7, '0);
        drive(1'b1, 1'b1, 1'b1, '0, '0);
        exp_rerr++;
        read_word(4'd7, 4'd1, 4'h0);
        idle(2);
        check("rerr_count_expired", rerr_seen, exp_rerr);

        write_word(4'd7, 4'd1, 4'h9);
        idle(95);
        drive(1'b0, 1'b1, 1'b1, 4'd7, '0);
        drive(1'b1, 1'b1, 1'b1, '0, '0);
        read_word(4'd7, 4'd1, 4'h9);
        idle(2);
        check("rerr_count_kept", rerr_seen, exp_rerr);

        // 6: simultaneous RAS/CAS fall must not write; reset mid-read
        do_reset();
        write_word(4'd4, 4'd4, 4'h3);
        drive(1'b0, 1'b0, 1'b0, 4'd4, 4'hF);
        exp_perr++;
        drive(1'b0, 1'b0, 1'b0, 4'd4, 4'hF);
        drive(1'b0, 1'b1, 1'b1, 4'd4, '0);
        drive(1'b1, 1'b1, 1'b1, '0, '0);
        read_word(4'd4, 4'd4, 4'h3);

        drive(1'b0, 1'b1, 1'b1, 4'd5, '0);
        exp_q.push_back(4'h0);
        drive(1'b0, 1'b0, 1'b1, 4'd9, '0);
        @(negedge clk);
        check("midread_oe_before_reset", dout_oe, 1);
        nreset = 1'b0;
        @(negedge clk);
        check("midread_reset_oe", dout_oe, 0);
        check("midread_reset_state", dbg_state, 0);
        set_pins(1'b1, 1'b1, 1'b1, '0, '0);
        @(negedge clk);
        nreset = 1'b1;
        idle(3);
        check("perr_count_final", perr_seen, exp_perr);
        check("rerr_count_final", rerr_seen, exp_rerr);
        check("reads_outstanding", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog: the stimulus runs well under 1000 cycles.
    initial begin
        #100000;
        errors++;
        checks++;
        $display("FAIL watchdog: stimulus did not complete by t=%0t", $time);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
